updn_mod_counter: RTL and testbench

UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

---
 rtl/updn_mod_counter.sv | 85 ++++++++
 tb/tb_updn_mod_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/updn_mod_counter.sv
// Up/down modulo counter with synchronous clear and parallel load, wrap or saturate at the range
// ends, sticky overflow/underflow flags and a combinational cascade carry.
module updn_mod_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 15,
    parameter int unsigned     SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero,
    output logic             ovf,
    output logic             unf
);

    // MODULUS may equal 2^WIDTH, so the top of the range is formed in 64 bits before truncation.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam bit               SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_max, at_min, load_over;

    assign at_max    = (q_q == MAX_Q);
    assign at_min    = (q_q == '0);
    assign load_over = (64'(load_val) >= MODULUS);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (load) begin
            q_d = load_over ? MAX_Q : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    q_d   = SAT ? MAX_Q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    unf_d = 1'b1;
                    q_d   = SAT ? '0 : MAX_Q;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= RST_Q;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Carry ignores clr/load so a cascade sees the terminal count whatever this stage does next.
    assign tc   = en & ((up_dn & at_max) | (~up_dn & at_min));
    assign zero = at_min;
    assign q    = q_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Bench for updn_mod_counter: three differently parameterised instances on shared inputs checked
// against a behavioural model, a directed vector table, corner sequences and a two-stage cascade.
module tb_updn_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1, clr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q_a [3];
    logic       tc_a [3], zero_a [3], ovf_a [3], unf_a [3];

    logic       ch_reset = 1'b1, ch_clr = 1'b0, ch_en = 1'b0;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, zero_lo, zero_hi, ovf_lo, ovf_hi, unf_lo, unf_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updn_mod_counter u_def (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q_a[0]), .tc(tc_a[0]), .zero(zero_a[0]), .ovf(ovf_a[0]),
        .unf(unf_a[0])
    );
    updn_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3), .SATURATE(0)) u_m10 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q_a[1]), .tc(tc_a[1]), .zero(zero_a[1]), .ovf(ovf_a[1]),
        .unf(unf_a[1])
    );
    updn_mod_counter #(.WIDTH(4), .MODULUS(12), .RESET_VAL(5), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q_a[2]), .tc(tc_a[2]), .zero(zero_a[2]), .ovf(ovf_a[2]),
        .unf(unf_a[2])
    );
    updn_mod_counter u_lo (
        .clk(clk), .reset(ch_reset), .en(ch_en), .up_dn(1'b1), .clr(ch_clr), .load(1'b0),
        .load_val(4'd0), .q(q_lo), .tc(tc_lo), .zero(zero_lo), .ovf(ovf_lo), .unf(unf_lo)
    );
    updn_mod_counter u_hi (
        .clk(clk), .reset(ch_reset), .en(tc_lo), .up_dn(1'b1), .clr(ch_clr), .load(1'b0),
        .load_val(4'd0), .q(q_hi), .tc(tc_hi), .zero(zero_hi), .ovf(ovf_hi), .unf(unf_hi)
    );

    // Behavioural model: one entry per shared-input instance.
    int mod_t [3] = '{16, 10, 12};
    int rv_t  [3] = '{15, 3, 5};
    int sat_t [3] = '{0, 0, 1};
    int mq [3];
    bit mo [3], mu [3];
    bit mvalid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mq[i] = rv_t[i]; mo[i] = 0; mu[i] = 0;
            end else if (clr) begin
                mq[i] = 0; mo[i] = 0; mu[i] = 0;
            end else if (load) begin
                mq[i] = (int'(load_val) < mod_t[i]) ? int'(load_val) : mod_t[i] - 1;
            end else if (en && up_dn) begin
                if (mq[i] + 1 == mod_t[i]) mo[i] = 1;
                mq[i] = (sat_t[i] != 0) ? ((mq[i] + 1 < mod_t[i]) ? mq[i] + 1 : mq[i])
                                        : (mq[i] + 1) % mod_t[i];
            end else if (en) begin
                if (mq[i] == 0) mu[i] = 1;
                mq[i] = (sat_t[i] != 0) ? ((mq[i] > 0) ? mq[i] - 1 : 0)
                                        : (mq[i] + mod_t[i] - 1) % mod_t[i];
            end
        end
        mvalid = 1'b1;
    endfunction

    // Inputs are already driven; check carry, clock once, then check the registered state.
    task automatic cycle();
        #1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("tc[%0d]", i), int'(tc_a[i]),
                      int'(en && ((up_dn && mq[i] == mod_t[i] - 1) || (!up_dn && mq[i] == 0))));
            end
        end
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("q[%0d]", i), int'(q_a[i]), mq[i]);
            check($sformatf("ovf[%0d]", i), int'(ovf_a[i]), int'(mo[i]));
            check($sformatf("unf[%0d]", i), int'(unf_a[i]), int'(mu[i]));
            check($sformatf("zero[%0d]", i), int'(zero_a[i]), int'(mq[i] == 0));
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit c, input bit l, input bit e, input bit u,
                         input bit [3:0] lv);
        reset = r; clr = c; load = l; en = e; up_dn = u; load_val = lv;
    endtask

    // Directed vectors with hand-derived expectations for the MODULUS=10 instance.
    typedef struct {
        bit       r, c, l, e, u;
        bit [3:0] lv;
        int       q;
        bit       o, n;
    } vec_t;
    vec_t vecs [$];

    initial begin
        int k;
        int hi_pulses, wraps;
        vecs.push_back('{1, 0, 0, 0, 0, 0, 3, 0, 0});   // reset
        vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0});   // clr
        for (int i = 1; i <= 9; i++) vecs.push_back('{0, 0, 0, 1, 1, 0, i, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 0});   // wrap 9 -> 0
        vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0});   // clr drops ovf
        vecs.push_back('{0, 0, 1, 1, 1, 13, 9, 0, 0});  // load beats en, clamped
        vecs.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 9, 1, 1});   // down wrap
        vecs.push_back('{0, 1, 1, 1, 1, 5, 0, 0, 0});   // clr beats load and en
        vecs.push_back('{1, 1, 0, 1, 1, 0, 3, 0, 0});   // reset beats clr
        vecs.push_back('{0, 0, 1, 0, 0, 7, 7, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 0, 7, 0, 0});   // en=0 holds
        vecs.push_back('{0, 0, 0, 1, 0, 0, 6, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 0, 7, 0, 0});   // direction flip, same edge

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].lv);
            cycle();
            check($sformatf("vec%0d_q", i), int'(q_a[1]), vecs[i].q);
            check($sformatf("vec%0d_ovf", i), int'(ovf_a[1]), int'(vecs[i].o));
            check($sformatf("vec%0d_unf", i), int'(unf_a[1]), int'(vecs[i].n));
        end

        // Default instance: reset then count down through the wrap.
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        check("def_reset_q", int'(q_a[0]), 15);
        for (k = 1; k <= 16; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            #1;
            check("def_tc_down", int'(tc_a[0]), int'(k == 16));
            cycle();
            check("def_q_down", int'(q_a[0]), (31 - k) % 16);
            check("def_unf_down", int'(unf_a[0]), int'(k == 16));
        end

        // Saturating instance: down from 2, then clamp and hold at the top.
        drive(0, 1, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 0, 0, 2);
        cycle();
        for (k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            cycle();
            check("sat_q_down", int'(q_a[2]), (2 - k > 0) ? 2 - k : 0);
            check("sat_unf", int'(unf_a[2]), int'(k >= 3));
            check("sat_zero", int'(zero_a[2]), int'(k >= 2));
        end
        drive(0, 0, 1, 0, 1, 15);
        cycle();
        check("sat_load_clamp", int'(q_a[2]), 11);
        drive(0, 0, 0, 1, 1, 0);
        cycle();
        check("sat_hold_top", int'(q_a[2]), 11);
        check("sat_ovf", int'(ovf_a[2]), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0);

        // Two-stage cascade: 256 up edges from zero.
        @(posedge clk);
        #1;
        ch_reset = 1'b0;
        ch_clr = 1'b1;
        @(posedge clk);
        #1;
        ch_clr = 1'b0;
        check("chain_start", int'({q_hi, q_lo}), 0);
        ch_en = 1'b1;
        hi_pulses = 0;
        wraps = 0;
        for (k = 1; k <= 256; k++) begin
            if (tc_hi) hi_pulses++;
            @(posedge clk);
            #1;
            check("chain_count", int'({q_hi, q_lo}), k % 256);
            if ({q_hi, q_lo} == 8'd0) wraps++;
        end
        ch_en = 1'b0;
        check("chain_wraps", wraps, 1);
        check("chain_hi_tc_pulses", hi_pulses, 1);
        check("chain_hi_ovf", int'(ovf_hi), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
